// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I types, writeback port and memory-stage helpers
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int DMEM_BE_W = 4;
  typedef enum logic [5:0] {
    UNKNOWN, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } operation_e;
  typedef struct packed {
    logic            valid;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } rd_port_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;
  function automatic logic is_load(operation_e op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction
  function automatic logic is_store(operation_e op);
    return op inside {SB, SH, SW};
  endfunction
endpackage

// File: rtl/memory_wb_lsu_align.sv
// lsu_align: byte-lane steering, store replication, load extraction and misalignment check
module lsu_align
  import riscv_pkg::*;
(
  input  operation_e            op_i,
  input  logic [XLEN-1:0]       addr_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [XLEN-1:0]       rdata_i,
  output logic [DMEM_BE_W-1:0]  be_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [XLEN-1:0]       load_o,
  output logic                  misaligned_o
);
  logic [1:0]      off;
  logic [XLEN-1:0] sh;
  assign off = addr_i[1:0];
  assign sh  = rdata_i >> {off, 3'b000};
  // lane enables, replicated write data and extended read data, all purely combinational
  always_comb begin
    be_o         = op_i == SB ? 4'b0001 << off : op_i == SH ? 4'b0011 << off : 4'b1111;
    wdata_o      = op_i == SB ? {4{rs2_i[7:0]}} : op_i == SH ? {2{rs2_i[15:0]}} : rs2_i;
    load_o       = op_i == LB  ? {{24{sh[7]}}, sh[7:0]} :
                   op_i == LBU ? {24'd0, sh[7:0]} :
                   op_i == LH  ? {{16{sh[15]}}, sh[15:0]} :
                   op_i == LHU ? {16'd0, sh[15:0]} : rdata_i;
    misaligned_o = ((op_i inside {LH, LHU, SH}) && off[0]) || ((op_i inside {LW, SW}) && off != 2'd0);
  end
endmodule

// File: rtl/memory_wb.sv
// memory_wb: memory-access/writeback stage driving the data-memory handshake and rd port
module memory_wb
  import riscv_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  validM_i,
  input  operation_e            operationM_i,
  input  logic [XLEN-1:0]       aluM_i,
  input  logic [XLEN-1:0]       rs2M_i,
  input  logic [4:0]            rdM_addr_i,
  input  logic                  rdM_wrt_ena_i,
  input  logic                  memM_wr_ena_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [DMEM_BE_W-1:0]  dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output rd_port_t              rdWB_port_o,
  output logic                  misaligned_o
);
  mem_state_e           state_q, state_d;
  operation_e           op_q, op_d;
  logic [XLEN-1:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [DMEM_BE_W-1:0] be_q, be_d;
  logic                 we_q, we_d, mis_q, mis_d;
  logic [4:0]           rd_q, rd_d;
  rd_port_t             wb_q, wb_d;
  logic                 accept;
  operation_e           a_op;
  logic [XLEN-1:0]      a_addr, a_wdata, a_load;
  logic [DMEM_BE_W-1:0] a_be;
  logic                 a_mis;
  assign accept = validM_i && state_q == IDLE;
  assign a_op   = state_q == IDLE ? operationM_i : op_q;
  assign a_addr = state_q == IDLE ? aluM_i : addr_q;
  lsu_align u_align (
    .op_i         (a_op),
    .addr_i       (a_addr),
    .rs2_i        (rs2M_i),
    .rdata_i      (dmem_rdata_i),
    .be_o         (a_be),
    .wdata_o      (a_wdata),
    .load_o       (a_load),
    .misaligned_o (a_mis)
  );
  // next state, captured request fields and single-cycle writeback/misaligned pulses
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rd_d    = rd_q;
    mis_d   = 1'b0;
    wb_d    = '0;
    if (accept) begin
      if (!(is_load(operationM_i) || is_store(operationM_i))) begin
        wb_d.valid = rdM_wrt_ena_i && rdM_addr_i != 5'd0;
        wb_d.addr  = rdM_addr_i;
        wb_d.data  = aluM_i;
      end else if (a_mis) begin
        mis_d = 1'b1;
      end else begin
        state_d = REQ;
        op_d    = operationM_i;
        addr_d  = aluM_i;
        wdata_d = a_wdata;
        be_d    = a_be;
        we_d    = memM_wr_ena_i;
        rd_d    = rdM_addr_i;
      end
    end else if (state_q == REQ && dmem_gnt_i) begin
      state_d = we_q ? IDLE : WAIT;
    end else if (state_q == WAIT && dmem_rvalid_i) begin
      state_d    = IDLE;
      wb_d.valid = rd_q != 5'd0;
      wb_d.addr  = rd_q;
      wb_d.data  = a_load;
    end
  end
  // state and output registers; reset drops any outstanding request at once
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      op_q    <= UNKNOWN;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      wb_q    <= wb_d;
    end
  end
  assign stall_o      = state_q != IDLE;
  assign dmem_req_o   = state_q == REQ;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rdWB_port_o  = wb_q;
  assign misaligned_o = mis_q;
endmodule
